// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// MEM/WB pipeline register. It captures the MEM-stage instruction, aligns
// and extends the load data, detects misaligned loads, and drives the
// register-file write port from registered state only. It also counts
// retired instructions.
//
// Parameters
//   DATA_W   register data width (default 32)
//   ADDR_W   register address width (default 5)
//
// Ports
//   clk       in   clock, all state updates on the rising edge
//   rst       in   synchronous active-high reset
//   stall     in   hold the current WB entry and ignore new input
//   flush     in   invalidate the WB entry at the next edge
//   m_valid   in   MEM stage presents an instruction
//   m_we      in   instruction writes a GPR
//   m_waddr   in   destination register
//   m_alu     in   ALU result or effective address
//   m_load    in   instruction is a load
//   m_ltype   in   load type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU
//   m_rdata   in   raw word from data memory
//   we        out  register-file write enable
//   wAddr     out  register-file write address
//   wData     out  register-file write data
//   adel      out  misaligned-load exception flag
//   badvaddr  out  faulting address of the last misaligned load
//   retired   out  count of retired instructions
// ---------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              m_valid,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] m_waddr,
    input  logic [DATA_W-1:0] m_alu,
    input  logic              m_load,
    input  logic [2:0]        m_ltype,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [DATA_W-1:0] wData,
    output logic              adel,
    output logic [DATA_W-1:0] badvaddr,
    output logic [31:0]       retired
);

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    logic              v_q;
    logic              we_q;
    logic              mis_q;

    logic [7:0]        loadByte;
    logic [15:0]       loadHalf;
    logic [DATA_W-1:0] loadData;
    logic              misaligned;
    logic [DATA_W-1:0] nextData;
    logic              capture;
    logic              retire;

    // Pick the addressed byte and halfword out of the raw memory word
    // (little-endian), then extend according to the load type. Codes
    // outside the defined set fall back to a full-word load, including
    // for the alignment check.
    always_comb begin
        loadByte   = m_rdata[7:0];
        loadHalf   = m_rdata[15:0];
        loadData   = m_rdata;
        misaligned = 1'b0;

        case (m_alu[1:0])
            2'b00:   loadByte = m_rdata[7:0];
            2'b01:   loadByte = m_rdata[15:8];
            2'b10:   loadByte = m_rdata[23:16];
            default: loadByte = m_rdata[31:24];
        endcase

        loadHalf = m_alu[1] ? m_rdata[31:16] : m_rdata[15:0];

        case (m_ltype)
            LT_LH: begin
                loadData   = {{(DATA_W-16){loadHalf[15]}}, loadHalf};
                misaligned = m_alu[0];
            end
            LT_LHU: begin
                loadData   = {{(DATA_W-16){1'b0}}, loadHalf};
                misaligned = m_alu[0];
            end
            LT_LB: begin
                loadData = {{(DATA_W-8){loadByte[7]}}, loadByte};
            end
            LT_LBU: begin
                loadData = {{(DATA_W-8){1'b0}}, loadByte};
            end
            default: begin
                loadData   = m_rdata;
                misaligned = (m_alu[1:0] != 2'b00);
            end
        endcase

        nextData = m_load ? loadData : m_alu;
    end

    // A new entry is accepted only on a clean edge. The outgoing entry
    // retires on that same kind of edge provided it is valid and did not
    // fault, so a capture and a retire can coincide without double counting.
    assign capture = ~stall & ~flush;
    assign retire  = v_q & ~mis_q & capture;

    // Pipeline register. Reset wins over flush, which wins over stall.
    // A flush only drops the valid bit; the payload is left as it was.
    // badvaddr is only updated by a faulting load so it keeps the most
    // recent faulting address.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q      <= 1'b0;
            we_q     <= 1'b0;
            mis_q    <= 1'b0;
            wAddr    <= '0;
            wData    <= '0;
            badvaddr <= '0;
        end else if (flush) begin
            v_q <= 1'b0;
        end else if (!stall) begin
            v_q   <= m_valid;
            we_q  <= m_we;
            mis_q <= m_load & misaligned;
            wAddr <= m_waddr;
            wData <= nextData;
            if (m_load && misaligned) begin
                badvaddr <= m_alu;
            end
        end
    end

    // Retirement counter; wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + 32'd1;
        end
    end

    // Outputs come only from registered state. Register 0 is never written,
    // and a faulting load raises adel instead of writing.
    assign we   = v_q & we_q & ~mis_q & (wAddr != '0);
    assign adel = v_q & mis_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Directed testbench for mem_wb_stage. Inputs change 1 time unit after a
// rising edge and outputs are checked 1 time unit after the following
// rising edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        m_valid;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_alu;
    logic        m_load;
    logic [2:0]  m_ltype;
    logic [31:0] m_rdata;
    logic        we;
    logic [4:0]  wAddr;
    logic [31:0] wData;
    logic        adel;
    logic [31:0] badvaddr;
    logic [31:0] retired;

    int testsRun;
    int testsFailed;

    mem_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .flush    (flush),
        .m_valid  (m_valid),
        .m_we     (m_we),
        .m_waddr  (m_waddr),
        .m_alu    (m_alu),
        .m_load   (m_load),
        .m_ltype  (m_ltype),
        .m_rdata  (m_rdata),
        .we       (we),
        .wAddr    (wAddr),
        .wData    (wData),
        .adel     (adel),
        .badvaddr (badvaddr),
        .retired  (retired)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic        valid,
                                 input logic        wen,
                                 input logic [4:0]  waddr,
                                 input logic [31:0] alu,
                                 input logic        load,
                                 input logic [2:0]  ltype,
                                 input logic [31:0] rdata);
        m_valid = valid;
        m_we    = wen;
        m_waddr = waddr;
        m_alu   = alu;
        m_load  = load;
        m_ltype = ltype;
        m_rdata = rdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h required 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic bubble();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b000, 32'h0);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        bubble();

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset we",       32'(we),       32'd0);
        checkOutput("reset adel",     32'(adel),     32'd0);
        checkOutput("reset wAddr",    32'(wAddr),    32'd0);
        checkOutput("reset wData",    wData,         32'd0);
        checkOutput("reset badvaddr", badvaddr,      32'd0);
        checkOutput("reset retired",  retired,       32'd0);

        // ALU write, one-cycle latency, retire on next unstalled edge
        applyStimulus(1'b1, 1'b1, 5'd5, 32'h12345678, 1'b0, 3'b000, 32'hAAAA5555);
        tick();
        checkOutput("alu we",      32'(we),    32'd1);
        checkOutput("alu wAddr",   32'(wAddr), 32'd5);
        checkOutput("alu wData",   wData,      32'h12345678);
        checkOutput("alu retired", retired,    32'd0);
        bubble();
        tick();
        checkOutput("alu retired+1", retired, 32'd1);
        checkOutput("bubble we",     32'(we), 32'd0);

        // Byte loads from 0x80FF7F01
        applyStimulus(1'b1, 1'b1, 5'd7, 32'h00001003, 1'b1, 3'b011, 32'h80FF7F01);
        tick();
        checkOutput("lb lane3 wData", wData,    32'hFFFFFF80);
        checkOutput("lb lane3 we",    32'(we),  32'd1);
        checkOutput("lb retired",     retired,  32'd1);
        applyStimulus(1'b1, 1'b1, 5'd7, 32'h00001003, 1'b1, 3'b100, 32'h80FF7F01);
        tick();
        checkOutput("lbu lane3 wData", wData,   32'h00000080);
        checkOutput("capture+retire",  retired, 32'd2);
        applyStimulus(1'b1, 1'b1, 5'd7, 32'h00001002, 1'b1, 3'b011, 32'h80FF7F01);
        tick();
        checkOutput("lb lane2 wData", wData, 32'hFFFFFFFF);
        applyStimulus(1'b1, 1'b1, 5'd7, 32'h00001001, 1'b1, 3'b011, 32'h80FF7F01);
        tick();
        checkOutput("lb lane1 wData", wData, 32'h0000007F);
        checkOutput("lb lane1 adel",  32'(adel), 32'd0);

        // Halfword loads from 0xBEEF1234
        applyStimulus(1'b1, 1'b1, 5'd8, 32'h00001002, 1'b1, 3'b010, 32'hBEEF1234);
        tick();
        checkOutput("lhu upper wData", wData,   32'h0000BEEF);
        checkOutput("lhu retired",     retired, 32'd5);
        applyStimulus(1'b1, 1'b1, 5'd8, 32'h00001002, 1'b1, 3'b001, 32'hBEEF1234);
        tick();
        checkOutput("lh upper wData", wData, 32'hFFFFBEEF);
        applyStimulus(1'b1, 1'b1, 5'd8, 32'h00001000, 1'b1, 3'b001, 32'hBEEF1234);
        tick();
        checkOutput("lh lower wData", wData, 32'h00001234);
        applyStimulus(1'b1, 1'b1, 5'd8, 32'h00001000, 1'b1, 3'b000, 32'hBEEF1234);
        tick();
        checkOutput("lw wData", wData, 32'hBEEF1234);

        // Misaligned LW at 0x1001
        applyStimulus(1'b1, 1'b1, 5'd9, 32'h00001001, 1'b1, 3'b000, 32'hBEEF1234);
        tick();
        checkOutput("mis lw adel",     32'(adel), 32'd1);
        checkOutput("mis lw badvaddr", badvaddr,  32'h00001001);
        checkOutput("mis lw we",       32'(we),   32'd0);
        checkOutput("mis lw retired",  retired,   32'd9);
        bubble();
        tick();
        checkOutput("mis not counted", retired,    32'd9);
        checkOutput("adel clears",     32'(adel),  32'd0);
        checkOutput("badvaddr holds",  badvaddr,   32'h00001001);

        // Misaligned LH at 0x2003
        applyStimulus(1'b1, 1'b1, 5'd9, 32'h00002003, 1'b1, 3'b001, 32'hBEEF1234);
        tick();
        checkOutput("mis lh adel",     32'(adel), 32'd1);
        checkOutput("mis lh badvaddr", badvaddr,  32'h00002003);

        // Write to register 0: no write, still retires
        applyStimulus(1'b1, 1'b1, 5'd0, 32'h0000DEAD, 1'b0, 3'b000, 32'h0);
        tick();
        checkOutput("x0 we", 32'(we), 32'd0);
        bubble();
        tick();
        checkOutput("x0 retired", retired, 32'd10);

        // Stall for 3 cycles with changing inputs, then flush under stall
        applyStimulus(1'b1, 1'b1, 5'd3, 32'hCAFEF00D, 1'b0, 3'b000, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 5'd4, 32'h11111111, 1'b0, 3'b000, 32'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall we",      32'(we),    32'd1);
            checkOutput("stall wAddr",   32'(wAddr), 32'd3);
            checkOutput("stall wData",   wData,      32'hCAFEF00D);
            checkOutput("stall retired", retired,    32'd10);
        end
        flush = 1'b1;
        tick();
        checkOutput("flush we",      32'(we), 32'd0);
        checkOutput("flush retired", retired, 32'd10);
        flush = 1'b0;
        stall = 1'b0;
        bubble();
        tick();
        checkOutput("flushed not counted", retired, 32'd10);

        // Wrap from 0xFFFFFFFF to 0
        applyStimulus(1'b1, 1'b1, 5'd1, 32'h00000001, 1'b0, 3'b000, 32'h0);
        tick();
        bubble();
        force dut.retired = 32'hFFFFFFFF;
        #1;
        release dut.retired;
        #1;
        checkOutput("preload retired", retired, 32'hFFFFFFFF);
        tick();
        checkOutput("wrap retired", retired, 32'd0);

        // Retire one more, then reset in the middle of a stall
        applyStimulus(1'b1, 1'b1, 5'd2, 32'h00000042, 1'b0, 3'b000, 32'h0);
        tick();
        bubble();
        tick();
        checkOutput("post-wrap retired", retired, 32'd1);
        applyStimulus(1'b1, 1'b1, 5'd6, 32'h00000077, 1'b0, 3'b000, 32'h0);
        tick();
        stall = 1'b1;
        tick();
        checkOutput("pre-reset we", 32'(we), 32'd1);
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        stall = 1'b0;
        bubble();
        checkOutput("rst we",       32'(we),    32'd0);
        checkOutput("rst wAddr",    32'(wAddr), 32'd0);
        checkOutput("rst wData",    wData,      32'd0);
        checkOutput("rst adel",     32'(adel),  32'd0);
        checkOutput("rst badvaddr", badvaddr,   32'd0);
        checkOutput("rst retired",  retired,    32'd0);
        tick();
        checkOutput("discarded not counted", retired, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_W, 32, register data width. ADDR_W, 5, register address width.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 stall  in  1  hold current WB entry; do not capture new input.
REQ-005 flush  in  1  invalidate WB entry at next edge.
REQ-006 m_valid  in  1  MEM stage presents an instruction.
REQ-007 m_we  in  1  instruction writes a GPR.
REQ-008 m_waddr  in  ADDR_W  destination register.
REQ-009 m_alu  in  DATA_W  ALU result or effective address.
REQ-010 m_load  in  1  instruction is a load.
REQ-011 m_ltype  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; other codes treated as LW.
REQ-012 m_rdata  in  DATA_W  raw word from data memory.
REQ-013 we, wAddr, wData  out  1/ADDR_W/DATA_W  register-file write port.
REQ-014 adel  out  1  misaligned-load exception flag.
REQ-015 badvaddr  out  DATA_W  faulting address.
REQ-016 retired  out  32  count of retired instructions.

Function
REQ-017 Capture SHALL occur at the rising edge when stall=0 and flush=0: v_q<=m_valid, plus all payload fields.
REQ-018 When stall=1 and flush=0, all registered state SHALL hold.
REQ-019 When flush=1, v_q SHALL clear at the edge regardless of stall; payload is don't-care.
REQ-020 Load data SHALL be aligned at capture, little-endian, lane k = m_alu[1:0].
REQ-021 LB/LBU: byte = m_rdata[8k+7:8k]. LB sign-extends to DATA_W. LBU zero-extends.
REQ-022 LH/LHU: half = m_rdata[15:0] if m_alu[1]=0, else m_rdata[31:16]. LH sign-extends. LHU zero-extends.
REQ-023 LW: wData = m_rdata.
REQ-024 Non-load: wData = m_alu.
REQ-025 Misalignment conditions: LW with m_alu[1:0]!=00, or LH/LHU with m_alu[0]=1. Misalignment SHALL set mis_q and capture badvaddr=m_alu.
REQ-026 we SHALL equal v_q & we_q & ~mis_q & (wAddr!=0). Register 0 is never written.
REQ-027 we/wAddr/wData SHALL remain asserted and stable throughout a stall, so the same value is rewritten each cycle.
REQ-028 adel SHALL equal v_q & mis_q. It is held during a stall.
REQ-029 Latency SHALL be one cycle: input captured at edge N appears on outputs after edge N and is written into the register file at edge N+1.
REQ-030 retired SHALL increment by 1 at each edge where v_q=1, mis_q=0, stall=0 and flush=0.
REQ-031 retired SHALL wrap from 0xFFFFFFFF to 0.
REQ-032 Simultaneous capture and retire SHALL count the outgoing entry only.
REQ-033 Outputs SHALL depend only on registered state (no combinational path from m_* to outputs).

Reset
REQ-034 At an edge with rst=1, the following SHALL clear: v_q, we_q, mis_q, wAddr, wData, badvaddr, retired. Reset has priority over flush and stall.
REQ-035 While v_q=0, the outputs SHALL be we=0 and adel=0.
REQ-036 Reset asserted mid-stall SHALL discard the held entry; it is neither written nor counted.

Verification
REQ-037 ALU write: m_valid=1, m_we=1, m_waddr=5, m_alu=0x12345678, m_load=0. Required: one cycle later we=1, wAddr=5, wData=0x12345678, and retired increments on the next unstalled edge.
REQ-038 LB sign: m_rdata=0x80FF7F01, m_alu[1:0]=11. Required: wData=0xFFFFFF80. Repeat with LBU: wData=0x00000080. With lane 10, LB gives 0xFFFFFFFF.
REQ-039 LHU upper half: m_rdata=0xBEEF1234, addr 0x1002. Required: wData=0x0000BEEF. Misaligned LW at 0x1001: adel=1, badvaddr=0x00001001, we=0, retired unchanged.
REQ-040 Write to $0: m_waddr=0, m_we=1. Required: we=0, and retired still increments.
REQ-041 Stall/flush: capture an entry, then stall=1 for 3 cycles. Required: outputs stable, retired unchanged. Then assert flush with stall=1: v_q=0 next cycle and the entry is not counted.
REQ-042 Reset: preload retired to 0xFFFFFFFF via 2^32-1 retirements (or force), then retire one more. Required: retired=0. Then rst=1 for 1 cycle: all outputs 0.
